// File: rtl/regfile_access_ctrl_if.sv
// regfile_access_ctrl_if: command/response channels plus register-file port bundle
interface regfile_access_ctrl_if #(parameter int DATA_W = 16, parameter int ADDR_W = 4);
  logic              Cmd_valid;
  logic              Cmd_ready;
  logic [1:0]        Cmd_op;
  logic [ADDR_W-1:0] Cmd_a;
  logic [ADDR_W-1:0] Cmd_b;
  logic [DATA_W-1:0] Cmd_data;
  logic              Rsp_valid;
  logic              Rsp_ready;
  logic [DATA_W-1:0] Rsp_src;
  logic [DATA_W-1:0] Rsp_dest;
  logic              Busy;
  logic [ADDR_W-1:0] RF_addr_A;
  logic [ADDR_W-1:0] RF_addr_B;
  logic [DATA_W-1:0] RF_data_in;
  logic              RF_WR;
  logic [DATA_W-1:0] RF_src;
  logic [DATA_W-1:0] RF_dest;
  modport master (
    output Cmd_valid, Cmd_op, Cmd_a, Cmd_b, Cmd_data, Rsp_ready, RF_src, RF_dest,
    input  Cmd_ready, Rsp_valid, Rsp_src, Rsp_dest, Busy, RF_addr_A, RF_addr_B, RF_data_in, RF_WR
  );
  modport slave (
    input  Cmd_valid, Cmd_op, Cmd_a, Cmd_b, Cmd_data, Rsp_ready, RF_src, RF_dest,
    output Cmd_ready, Rsp_valid, Rsp_src, Rsp_dest, Busy, RF_addr_A, RF_addr_B, RF_data_in, RF_WR
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: command-driven READ/WRITE/MOVE/CLEAR initiator for a 16x16 register file
module regfile_access_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input logic CLK,
  input logic RSTn,
  regfile_access_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READ, RESP, WRITE, MOVE_RD, MOVE_WR, CLEAR} state_t;
  state_t state, state_d;
  logic [ADDR_W-1:0] addr_a, addr_a_d, addr_b, addr_b_d, cnt, cnt_d;
  logic [DATA_W-1:0] data, data_d, src, src_d, dest, dest_d;
  logic wr, wr_d, vld, vld_d;
  always_comb begin
    state_d  = state;
    addr_a_d = addr_a;
    addr_b_d = addr_b;
    data_d   = data;
    src_d    = src;
    dest_d   = dest;
    cnt_d    = cnt;
    vld_d    = vld;
    wr_d     = 1'b0;
    case (state)
      IDLE: if (bus.Cmd_valid) begin
        addr_a_d = bus.Cmd_a;
        addr_b_d = bus.Cmd_b;
        case (bus.Cmd_op)
          2'b00: state_d = READ;
          2'b01: begin
            state_d = WRITE;
            data_d  = bus.Cmd_data;
            wr_d    = 1'b1;
          end
          2'b10: state_d = MOVE_RD;
          default: begin
            state_d  = CLEAR;
            addr_b_d = '0;
            data_d   = '0;
            cnt_d    = '0;
            wr_d     = 1'b1;
          end
        endcase
      end
      READ: begin
        src_d   = bus.RF_src;
        dest_d  = bus.RF_dest;
        vld_d   = 1'b1;
        state_d = RESP;
      end
      RESP: if (bus.Rsp_ready) begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
      MOVE_RD: begin
        data_d  = bus.RF_src;
        wr_d    = 1'b1;
        state_d = MOVE_WR;
      end
      // last sweep address stops here so the write enable drops without wrapping
      CLEAR: if (cnt == ADDR_W'(NUM_REGS - 1)) state_d = IDLE;
      else begin
        cnt_d    = cnt + 1'b1;
        addr_b_d = cnt + 1'b1;
        wr_d     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state  <= IDLE;
      addr_a <= '0;
      addr_b <= '0;
      data   <= '0;
      src    <= '0;
      dest   <= '0;
      cnt    <= '0;
      vld    <= 1'b0;
      wr     <= 1'b0;
    end else begin
      state  <= state_d;
      addr_a <= addr_a_d;
      addr_b <= addr_b_d;
      data   <= data_d;
      src    <= src_d;
      dest   <= dest_d;
      cnt    <= cnt_d;
      vld    <= vld_d;
      wr     <= wr_d;
    end
  end
  assign bus.Cmd_ready  = state == IDLE;
  assign bus.Busy       = state != IDLE;
  assign bus.RF_addr_A  = addr_a;
  assign bus.RF_addr_B  = addr_b;
  assign bus.RF_data_in = data;
  assign bus.RF_WR      = wr;
  assign bus.Rsp_valid  = vld;
  assign bus.Rsp_src    = src;
  assign bus.Rsp_dest   = dest;
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: random commands against a register-file model and a command-level reference
module tb_regfile_access_ctrl;
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;
  regfile_access_ctrl_if bus ();
  regfile_access_ctrl dut (.CLK(CLK), .RSTn(RSTn), .bus(bus.slave));
  logic [15:0] rf [16] = '{default: 16'h0};
  logic [15:0] ref_mem [16] = '{default: 16'h0};
  int n_tests = 0;
  int n_fail = 0;
  always @(posedge CLK) if (bus.RF_WR) rf[bus.RF_addr_B] <= bus.RF_data_in;
  assign bus.RF_src  = rf[bus.RF_addr_A];
  assign bus.RF_dest = rf[bus.RF_addr_B];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [15:0] d, output int w);
    bus.Cmd_valid = 1'b1;
    bus.Cmd_op    = op;
    bus.Cmd_a     = a;
    bus.Cmd_b     = b;
    bus.Cmd_data  = d;
    w = 0;
    while (!bus.Cmd_ready && w < 64) begin
      @(negedge CLK);
      w++;
    end
    if (!bus.Cmd_ready) chk("accept_timeout", 32'(w), 32'd0);
    @(negedge CLK);
    bus.Cmd_valid = 1'b0;
    chk("busy_after_accept", {bus.Busy, bus.Cmd_ready}, 2'b10);
  endtask
  task automatic do_write(input logic [3:0] b, input logic [15:0] d, input bit tail, output int w);
    send(2'b01, 4'($urandom), b, d, w);
    chk("wr_pulse", bus.RF_WR, 1'b1);
    chk("wr_addr", bus.RF_addr_B, b);
    chk("wr_data", bus.RF_data_in, d);
    ref_mem[b] = d;
    if (tail) begin
      @(negedge CLK);
      chk("wr_end", {bus.RF_WR, bus.Cmd_ready}, 2'b01);
    end
  endtask
  task automatic do_read(input logic [3:0] a, input logic [3:0] b, input int hold);
    int w;
    send(2'b00, a, b, 16'($urandom), w);
    chk("rd_early_valid", bus.Rsp_valid, 1'b0);
    bus.Rsp_ready = (hold == 0);
    @(negedge CLK);
    chk("rd_valid", bus.Rsp_valid, 1'b1);
    chk("rd_src", bus.Rsp_src, ref_mem[a]);
    chk("rd_dest", bus.Rsp_dest, ref_mem[b]);
    repeat (hold) begin
      @(negedge CLK);
      chk("rd_hold", {bus.Rsp_valid, bus.Cmd_ready, bus.Rsp_src, bus.Rsp_dest},
          {2'b10, ref_mem[a], ref_mem[b]});
    end
    bus.Rsp_ready = 1'b1;
    @(negedge CLK);
    chk("rd_done", {bus.Rsp_valid, bus.Cmd_ready}, 2'b01);
    bus.Rsp_ready = 1'b0;
  endtask
  task automatic do_move(input logic [3:0] a, input logic [3:0] b);
    int w;
    logic [15:0] e;
    e = ref_mem[a];
    send(2'b10, a, b, 16'($urandom), w);
    chk("mv_rd_wr", bus.RF_WR, 1'b0);
    @(negedge CLK);
    chk("mv_wr", {bus.RF_WR, bus.RF_addr_B, bus.RF_data_in}, {1'b1, b, e});
    @(negedge CLK);
    chk("mv_end", {bus.RF_WR, bus.Cmd_ready}, 2'b01);
    ref_mem[b] = e;
  endtask
  task automatic do_clear(input int stop);
    int w;
    send(2'b11, 4'($urandom), 4'($urandom), 16'($urandom), w);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge CLK);
      chk("clr_step", {bus.RF_WR, bus.Busy, bus.RF_addr_B, bus.RF_data_in}, {2'b11, 4'(i), 16'h0});
      if (i == stop) begin
        RSTn = 1'b0;
        @(negedge CLK);
        chk("rst_mid", {bus.RF_WR, bus.Cmd_ready, bus.Busy, bus.Rsp_valid, bus.RF_addr_B}, {4'b0100, 4'h0});
        RSTn = 1'b1;
        for (int j = 0; j <= i; j++) ref_mem[j] = 16'h0;
        return;
      end
    end
    @(negedge CLK);
    chk("clr_end", {bus.RF_WR, bus.Busy}, 2'b00);
    for (int j = 0; j < 16; j++) ref_mem[j] = 16'h0;
  endtask
  initial begin
    int w, w2, op;
    bus.Cmd_valid = 1'b1;
    bus.Cmd_op    = 2'b01;
    bus.Cmd_a     = 4'h3;
    bus.Cmd_b     = 4'h3;
    bus.Cmd_data  = 16'hFFFF;
    bus.Rsp_ready = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_ctrl", {bus.RF_WR, bus.Rsp_valid, bus.Cmd_ready, bus.Busy}, 4'b0010);
    chk("rst_addr", {bus.RF_addr_A, bus.RF_addr_B, bus.RF_data_in}, 24'h0);
    chk("rst_rsp", {bus.Rsp_src, bus.Rsp_dest}, 32'h0);
    bus.Cmd_valid = 1'b0;
    RSTn = 1'b1;
    @(negedge CLK);
    do_write(4'd1, 16'h1234, 1'b0, w);
    do_write(4'd7, 16'h5678, 1'b1, w2);
    chk("b2b_accept_wait", 32'(w2), 32'd1);
    do_read(4'd7, 4'd1, 3);
    do_move(4'd7, 4'd4);
    do_read(4'd4, 4'd5, 0);
    do_clear(-1);
    do_read(4'd7, 4'd1, 1);
    for (int k = 0; k < 80; k++) begin
      op = $urandom_range(0, 9);
      if (op < 4) do_write(4'($urandom), 16'($urandom), 1'($urandom), w);
      else if (op < 7) do_read(4'($urandom), 4'($urandom), $urandom_range(0, 3));
      else if (op < 9) do_move(4'($urandom), 4'($urandom));
      else do_clear(-1);
      if (!bus.Cmd_ready) @(negedge CLK);
    end
    for (int i = 0; i < 16; i++) do_write(4'(i), 16'hA5A5, 1'b1, w);
    do_clear(5);
    for (int i = 0; i < 16; i++) do_read(4'(i), 4'(15 - i), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
